// File: rtl/data_ram_ws.sv
// ----------------------------------------------------------------------------
// data_ram_ws -- word-organised data RAM with a fixed number of wait states.
//
// A request presented with ce=1 while idle is captured, held for WAIT_CYCLES
// cycles and then completed with a one-cycle ack_o pulse. Writes are
// byte-masked by sel (sel[3] -> data[31:24]). Reads return the whole word.
//
// Ports:
//   clk     in   single clock, rising edge
//   rst     in   synchronous active-high reset (storage is not cleared)
//   ce      in   request valid
//   we      in   1 = write, 0 = read
//   addr    in   byte address; word index = addr[DEPTH_LOG2+1:2]
//   sel     in   byte-lane enables for writes
//   data_i  in   write data
//   data_o  out  read data while ack_o = 1 (zero on write ack)
//   ack_o   out  one-cycle completion pulse
//   busy_o  out  high from acceptance through the ack cycle
// ----------------------------------------------------------------------------
module data_ram_ws #(
  parameter int unsigned DEPTH_LOG2  = 10,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [3:0]  sel,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        ack_o,
  output logic        busy_o
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } state_t;

  state_t                state;
  logic [3:0]            cnt;
  logic                  we_q;
  logic [DEPTH_LOG2-1:0] idx_q;
  logic [3:0]            sel_q;
  logic [31:0]           wdata_q;
  logic [31:0]           rd_q;

  logic [31:0]           mem [DEPTH];

  logic                  accept;
  logic                  enter_ack;
  logic                  op_we;
  logic [DEPTH_LOG2-1:0] op_idx;
  logic [3:0]            op_sel;
  logic [31:0]           op_wdata;

  // Address bits outside the word index are deliberately ignored (aliasing).
  logic unused_addr_bits;
  assign unused_addr_bits = ^{addr[31:DEPTH_LOG2+2], addr[1:0]};

  assign accept = (state == IDLE) && ce;

  // With zero wait states the access happens on the accepting edge itself,
  // so the operation is taken straight from the ports; otherwise it comes
  // from the registers captured at acceptance.
  always_comb begin
    op_we     = we_q;
    op_idx    = idx_q;
    op_sel    = sel_q;
    op_wdata  = wdata_q;
    enter_ack = 1'b0;
    if (state == IDLE) begin
      op_we    = we;
      op_idx   = addr[DEPTH_LOG2+1:2];
      op_sel   = sel;
      op_wdata = data_i;
      enter_ack = !rst && accept && (WAIT_CYCLES == 0);
    end else if (state == WAIT) begin
      enter_ack = !rst && (cnt == 4'd1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      we_q    <= 1'b0;
      idx_q   <= '0;
      sel_q   <= '0;
      wdata_q <= '0;
      rd_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            we_q    <= we;
            idx_q   <= addr[DEPTH_LOG2+1:2];
            sel_q   <= sel;
            wdata_q <= data_i;
            cnt     <= 4'(WAIT_CYCLES);
            state   <= (WAIT_CYCLES == 0) ? ACK : WAIT;
          end
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state <= ACK;
          end
        end
        ACK: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase

      // Read data is latched once and held until the next read completes.
      if (enter_ack && !op_we) begin
        rd_q <= mem[op_idx];
      end
    end
  end

  // Storage has no reset; enter_ack is already suppressed while rst is high.
  always_ff @(posedge clk) begin
    if (enter_ack && op_we) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (op_sel[b]) begin
          mem[op_idx][8*b +: 8] <= op_wdata[8*b +: 8];
        end
      end
    end
  end

  assign ack_o  = (state == ACK);
  assign busy_o = (state != IDLE);
  assign data_o = ((state == ACK) && we_q) ? '0 : rd_q;

endmodule

// File: tb/tb_data_ram_ws.sv
// ----------------------------------------------------------------------------
// tb_data_ram_ws -- self-checking bench for data_ram_ws.
// Instance 0 uses two wait states, instance 1 uses none. A word-array model
// with byte-mask merging predicts read data; handshake timing is predicted
// from the configured wait-state count.
// ----------------------------------------------------------------------------
module tb_data_ram_ws;

  logic        clk;
  logic        rst;
  logic        ce_v     [2];
  logic        we_v     [2];
  logic [31:0] addr_v   [2];
  logic [3:0]  sel_v    [2];
  logic [31:0] data_i_v [2];
  logic [31:0] data_o_v [2];
  logic        ack_v    [2];
  logic        busy_v   [2];

  int n_tests;
  int n_fail;

  logic [31:0] model [2][1024];

  data_ram_ws #(.DEPTH_LOG2(10), .WAIT_CYCLES(2)) dut_ws2 (
    .clk(clk), .rst(rst), .ce(ce_v[0]), .we(we_v[0]), .addr(addr_v[0]),
    .sel(sel_v[0]), .data_i(data_i_v[0]), .data_o(data_o_v[0]),
    .ack_o(ack_v[0]), .busy_o(busy_v[0])
  );

  data_ram_ws #(.DEPTH_LOG2(10), .WAIT_CYCLES(0)) dut_ws0 (
    .clk(clk), .rst(rst), .ce(ce_v[1]), .we(we_v[1]), .addr(addr_v[1]),
    .sel(sel_v[1]), .data_i(data_i_v[1]), .data_o(data_o_v[1]),
    .ack_o(ack_v[1]), .busy_o(busy_v[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int wc(input int u);
    return (u == 0) ? 2 : 0;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] mask;
    mask = 32'h0;
    for (int b = 0; b < 4; b++)
      if (s[b]) mask = mask | (32'hFF << (8 * b));
    return (old & ~mask) | (d & mask);
  endfunction

  // One transaction, started at a negedge with the DUT idle; ends at a negedge
  // with the DUT idle again.
  task automatic txn(input int u, input bit w, input logic [31:0] a,
                     input logic [3:0] s, input logic [31:0] d,
                     input string tag, output logic [31:0] rd);
    int   edges;
    int   busy_n;
    bit   got;
    logic [31:0] exp;
    ce_v[u] = 1'b1; we_v[u] = w; addr_v[u] = a; sel_v[u] = s; data_i_v[u] = d;
    exp = w ? 32'h0 : model[u][a[11:2]];
    got = 0; busy_n = 0; edges = 0; rd = 'x;
    @(posedge clk);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      edges = k + 1;
      if (busy_v[u]) busy_n++;
      if (ack_v[u]) begin
        got = 1;
        rd = data_o_v[u];
        ce_v[u] = 1'b0;
        break;
      end
      // Inputs must be ignored while the transaction is in flight.
      ce_v[u] = 1'($urandom_range(0, 1)); we_v[u] = 1'($urandom_range(0, 1));
      addr_v[u] = $urandom; sel_v[u] = 4'($urandom); data_i_v[u] = $urandom;
    end
    ce_v[u] = 1'b0;
    n_tests++;
    if (!got) begin
      n_fail++;
      $display("FAIL %s u%0d: ack timeout, got none, required after %0d edges", tag, u, wc(u) + 1);
    end else begin
      n_tests++;
      if (edges !== wc(u) + 1) begin
        n_fail++;
        $display("FAIL %s u%0d latency: got %0d edges, required %0d", tag, u, edges, wc(u) + 1);
      end
      n_tests++;
      if (busy_n !== wc(u) + 1) begin
        n_fail++;
        $display("FAIL %s u%0d busy cycles: got %0d, required %0d", tag, u, busy_n, wc(u) + 1);
      end
      if (rd !== exp) begin
        n_fail++;
        $display("FAIL %s u%0d data_o: got %h, required %h", tag, u, rd, exp);
      end
    end
    if (w) model[u][a[11:2]] = merge(model[u][a[11:2]], d, s);
    @(negedge clk);
    n_tests++;
    if (ack_v[u] !== 1'b0 || busy_v[u] !== 1'b0) begin
      n_fail++;
      $display("FAIL %s u%0d post-ack idle: ack=%b busy=%b, required 0 0", tag, u, ack_v[u], busy_v[u]);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int u = 0; u < 2; u++) begin
      ce_v[u] = 0; we_v[u] = 0; addr_v[u] = 0; sel_v[u] = 0; data_i_v[u] = 0;
    end
    repeat (3) @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      n_tests++;
      if (ack_v[u] !== 1'b0 || busy_v[u] !== 1'b0 || data_o_v[u] !== 32'h0) begin
        n_fail++;
        $display("FAIL reset u%0d: ack=%b busy=%b data_o=%h, required 0 0 00000000",
                 u, ack_v[u], busy_v[u], data_o_v[u]);
      end
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_directed();
    logic [31:0] rd;
    txn(0, 1, 32'h0000_0010, 4'hF, 32'h1234_5678, "w_full", rd);
    txn(0, 0, 32'h0000_0010, 4'hF, 32'h0, "r_full", rd);
    n_tests++;
    if (rd !== 32'h1234_5678) begin
      n_fail++; $display("FAIL full_word: got %h, required 12345678", rd);
    end
    txn(0, 1, 32'h0000_0010, 4'b0100, 32'h00AB_0000, "w_merge", rd);
    txn(0, 0, 32'h0000_0010, 4'b0000, 32'h0, "r_merge", rd);
    n_tests++;
    if (rd !== 32'h12AB_5678) begin
      n_fail++; $display("FAIL byte_merge: got %h, required 12AB5678", rd);
    end
    txn(0, 1, 32'h0000_1010, 4'hF, 32'hDEAD_BEEF, "w_wrap", rd);
    txn(0, 0, 32'h0000_0013, 4'hF, 32'h0, "r_wrap", rd);
    n_tests++;
    if (rd !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL wrap: got %h, required DEADBEEF", rd);
    end
    txn(0, 1, 32'h0000_0010, 4'b0000, 32'h5555_AAAA, "w_sel0", rd);
    txn(0, 0, 32'h0000_0010, 4'hF, 32'h0, "r_sel0", rd);
    n_tests++;
    if (rd !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL sel_zero: got %h, required DEADBEEF", rd);
    end
    // Zero-wait-state instance.
    txn(1, 1, 32'h0000_0010, 4'hF, 32'hCAFE_F00D, "w_ws0", rd);
    txn(1, 1, 32'h0000_0020, 4'hF, 32'h0BAD_C0DE, "w_ws0b", rd);
    txn(1, 0, 32'h0000_0010, 4'hF, 32'h0, "r_ws0", rd);
    n_tests++;
    if (rd !== 32'hCAFE_F00D) begin
      n_fail++; $display("FAIL ws0_read: got %h, required CAFEF00D", rd);
    end
    txn(0, 1, 32'h0000_0020, 4'hF, 32'h7777_1111, "w_x20", rd);
  endtask

  task automatic test_reset_mid_op();
    logic [31:0] rd;
    ce_v[0] = 1; we_v[0] = 1; addr_v[0] = 32'h10; sel_v[0] = 4'hF; data_i_v[0] = 32'hFFFF_FFFF;
    @(posedge clk);
    @(negedge clk);
    ce_v[0] = 0;
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_tests++;
      if (ack_v[0] !== 1'b0 || busy_v[0] !== 1'b0 || data_o_v[0] !== 32'h0) begin
        n_fail++;
        $display("FAIL rst_mid_op cyc%0d: ack=%b busy=%b data_o=%h, required 0 0 00000000",
                 k, ack_v[0], busy_v[0], data_o_v[0]);
      end
    end
    rst = 1'b0;
    @(negedge clk);
    txn(0, 0, 32'h10, 4'hF, 32'h0, "r_after_rst", rd);
    n_tests++;
    if (rd !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL rst_no_write: got %h, required DEADBEEF", rd);
    end
  endtask

  task automatic test_back_to_back(input int u);
    int t_ack[$];
    logic [31:0] d_ack[$];
    int idle_n;
    ce_v[u] = 1; we_v[u] = 0; addr_v[u] = 32'h10; sel_v[u] = 4'hF; data_i_v[u] = 0;
    idle_n = 0;
    @(posedge clk);
    @(negedge clk);
    addr_v[u] = 32'h20;
    for (int cyc = 0; cyc < 30; cyc++) begin
      if (ack_v[u]) begin
        t_ack.push_back(cyc);
        d_ack.push_back(data_o_v[u]);
      end else if (t_ack.size() == 1 && !busy_v[u]) begin
        idle_n++;
      end
      if (t_ack.size() == 2) begin
        ce_v[u] = 0;
        break;
      end
      @(negedge clk);
    end
    ce_v[u] = 0;
    n_tests++;
    if (t_ack.size() != 2) begin
      n_fail++;
      $display("FAIL b2b u%0d acks: got %0d, required 2", u, t_ack.size());
    end else begin
      n_tests += 3;
      if (t_ack[1] - t_ack[0] != wc(u) + 2 || idle_n != 1) begin
        n_fail++;
        $display("FAIL b2b u%0d spacing: got gap %0d idle %0d, required gap %0d idle 1",
                 u, t_ack[1] - t_ack[0], idle_n, wc(u) + 2);
      end
      if (d_ack[0] !== model[u][4]) begin
        n_fail++; $display("FAIL b2b u%0d data0: got %h, required %h", u, d_ack[0], model[u][4]);
      end
      if (d_ack[1] !== model[u][8]) begin
        n_fail++; $display("FAIL b2b u%0d data1: got %h, required %h", u, d_ack[1], model[u][8]);
      end
    end
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_random(input int u);
    logic [31:0] rd;
    logic [31:0] a;
    for (int i = 0; i < 16; i++)
      txn(u, 1, 32'(i) << 2, 4'hF, $urandom, "r_init", rd);
    for (int n = 0; n < 60; n++) begin
      a = ($urandom & 32'hFFFF_F003) | (32'($urandom_range(0, 15)) << 2);
      txn(u, 1'($urandom_range(0, 1)), a, 4'($urandom), $urandom, "rand", rd);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    @(negedge clk);
    test_reset();
    test_directed();
    test_reset_mid_op();
    test_back_to_back(0);
    test_back_to_back(1);
    test_random(0);
    test_random(1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
